// File: rtl/mt_fetch_sched.sv
// N-thread round-robin fetch scheduler with per-thread PC file.
// Issues one eligible thread's PC per cycle to instruction memory, tagged with its thread ID.
module mt_fetch_sched #(
  parameter int NUM_THREADS = 4,
  parameter int TID_WIDTH   = 2,
  parameter int PC_WIDTH    = 9,
  parameter int PC_STEP     = 1,
  parameter int BOOT_SHIFT  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] thread_en_i,
  input  logic                   fetch_stall_i,
  input  logic                   redirect_valid_i,
  input  logic [TID_WIDTH-1:0]   redirect_tid_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  input  logic                   halt_valid_i,
  input  logic [TID_WIDTH-1:0]   halt_tid_i,
  output logic [PC_WIDTH-1:0]    i_mem_addr_o,
  output logic                   fetch_valid_o,
  output logic [TID_WIDTH-1:0]   fetch_tid_o,
  output logic [NUM_THREADS-1:0] active_mask_o,
  output logic                   all_halted_o
);

  localparam int                  CW     = TID_WIDTH + 1;
  localparam logic [CW-1:0]       NT_W   = CW'(NUM_THREADS);
  localparam logic [PC_WIDTH-1:0] STEP_W = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0]    pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] halted_q, halted_d;
  logic [TID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;

  logic [NUM_THREADS-1:0] active_s;
  logic [TID_WIDTH-1:0]   sel_s;
  logic                   found_s;
  logic                   issue_s;
  logic                   redirect_ok_s;
  logic                   halt_ok_s;

  assign active_s      = thread_en_i & ~halted_q;
  assign issue_s       = !fetch_stall_i && found_s;
  assign redirect_ok_s = redirect_valid_i && ({1'b0, redirect_tid_i} < NT_W);
  assign halt_ok_s     = halt_valid_i && ({1'b0, halt_tid_i} < NT_W);

  // Round-robin search starting just after the last issued thread.
  always_comb begin
    logic [CW-1:0] cand;
    cand    = '0;
    sel_s   = rr_ptr_q;
    found_s = 1'b0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= NT_W) begin
        cand = cand - NT_W;
      end else begin
        cand = cand;
      end
      if (!found_s && active_s[cand[TID_WIDTH-1:0]]) begin
        sel_s   = cand[TID_WIDTH-1:0];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Output-register and pointer next state: issue, hold on stall, or go idle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    tid_d    = tid_q;
    valid_d  = valid_q;
    if (issue_s) begin
      addr_d   = pc_q[sel_s];
      tid_d    = sel_s;
      valid_d  = 1'b1;
      rr_ptr_d = sel_s;
    end else if (!fetch_stall_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Per-thread PC and halt next state; redirect beats increment, halt beats redirect's un-halt.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (redirect_ok_s && (redirect_tid_i == TID_WIDTH'(t))) begin
        pc_d[t] = redirect_pc_i;
      end else if (issue_s && (sel_s == TID_WIDTH'(t))) begin
        pc_d[t] = pc_q[t] + STEP_W;
      end else begin
        pc_d[t] = pc_q[t];
      end
      if (halt_ok_s && (halt_tid_i == TID_WIDTH'(t))) begin
        halted_d[t] = 1'b1;
      end else if (redirect_ok_s && (redirect_tid_i == TID_WIDTH'(t))) begin
        halted_d[t] = 1'b0;
      end else begin
        halted_d[t] = halted_q[t];
      end
    end
  end

  // State registers with synchronous reset to boot PCs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= PC_WIDTH'(t << BOOT_SHIFT);
      end
      halted_q <= '0;
      rr_ptr_q <= TID_WIDTH'(NUM_THREADS - 1);
      addr_q   <= '0;
      valid_q  <= 1'b0;
      tid_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      tid_q    <= tid_d;
    end
  end

  assign i_mem_addr_o  = addr_q;
  assign fetch_valid_o = valid_q;
  assign fetch_tid_o   = tid_q;
  assign active_mask_o = active_s;
  assign all_halted_o  = ~|active_s;

endmodule

// File: tb/tb_mt_fetch_sched.sv
// Directed table-driven bench for mt_fetch_sched (default 4-thread configuration).
module tb_mt_fetch_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] thread_en_i;
  logic       fetch_stall_i;
  logic       redirect_valid_i;
  logic [1:0] redirect_tid_i;
  logic [8:0] redirect_pc_i;
  logic       halt_valid_i;
  logic [1:0] halt_tid_i;
  logic [8:0] i_mem_addr_o;
  logic       fetch_valid_o;
  logic [1:0] fetch_tid_o;
  logic [3:0] active_mask_o;
  logic       all_halted_o;

  int tests = 0;
  int fails = 0;
  int row   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       stall;
    logic       rv;
    logic [1:0] rtid;
    logic [8:0] rpc;
    logic       hv;
    logic [1:0] htid;
    logic       ev;
    logic [1:0] etid;
    logic [8:0] eaddr;
    logic [3:0] emask;
    logic       eallh;
  } vec_t;

  vec_t tbl[$];

  mt_fetch_sched dut (
    .clk              (clk),
    .rst              (rst),
    .thread_en_i      (thread_en_i),
    .fetch_stall_i    (fetch_stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_tid_i   (redirect_tid_i),
    .redirect_pc_i    (redirect_pc_i),
    .halt_valid_i     (halt_valid_i),
    .halt_tid_i       (halt_tid_i),
    .i_mem_addr_o     (i_mem_addr_o),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_tid_o      (fetch_tid_o),
    .active_mask_o    (active_mask_o),
    .all_halted_o     (all_halted_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic [3:0] en, input logic st,
                             input logic rv, input logic [1:0] rtid, input logic [8:0] rpc,
                             input logic hv, input logic [1:0] htid,
                             input logic ev, input logic [1:0] etid, input logic [8:0] eaddr,
                             input logic [3:0] emask, input logic eallh);
    vec_t x;
    x.rst = r; x.en = en; x.stall = st; x.rv = rv; x.rtid = rtid; x.rpc = rpc;
    x.hv = hv; x.htid = htid; x.ev = ev; x.etid = etid; x.eaddr = eaddr;
    x.emask = emask; x.eallh = eallh;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then check the post-edge outputs.
  task automatic apply(input vec_t x);
    rst              = x.rst;
    thread_en_i      = x.en;
    fetch_stall_i    = x.stall;
    redirect_valid_i = x.rv;
    redirect_tid_i   = x.rtid;
    redirect_pc_i    = x.rpc;
    halt_valid_i     = x.hv;
    halt_tid_i       = x.htid;
    @(posedge clk);
    #1;
    chk("valid", 32'(fetch_valid_o), 32'(x.ev));
    chk("tid",   32'(fetch_tid_o),   32'(x.etid));
    chk("addr",  32'(i_mem_addr_o),  32'(x.eaddr));
    chk("mask",  32'(active_mask_o), 32'(x.emask));
    chk("allh",  32'(all_halted_o),  32'(x.eallh));
    row++;
  endtask

  initial begin
    rst = 1'b1; thread_en_i = 4'h0; fetch_stall_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_tid_i = 2'd0; redirect_pc_i = 9'd0;
    halt_valid_i = 1'b0; halt_tid_i = 2'd0;

    // Reset, then plain round-robin over all four threads
    tbl.push_back(v(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0,   4'hF, 1'b0));
    tbl.push_back(v(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0,   4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd0,   4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd1, 9'd64,  4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd2, 9'd128, 4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd3, 9'd192, 4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd1,   4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd1, 9'd65,  4'hF, 1'b0));
    // Sparse enable 0101
    tbl.push_back(v(1'b1, 4'h5, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0,   4'h5, 1'b0));
    tbl.push_back(v(1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd0,   4'h5, 1'b0));
    tbl.push_back(v(1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd2, 9'd128, 4'h5, 1'b0));
    tbl.push_back(v(1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd1,   4'h5, 1'b0));
    tbl.push_back(v(1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd2, 9'd129, 4'h5, 1'b0));
    // Three-cycle stall after (1,64)
    tbl.push_back(v(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0,   4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd0,   4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd1, 9'd64,  4'hF, 1'b0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd1, 9'd64, 4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd2, 9'd128, 4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd3, 9'd192, 4'hF, 1'b0));
    tbl.push_back(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd1,   4'hF, 1'b0));
    // Enable drop keeps PC; all-disabled goes idle
    tbl.push_back(v(1'b1, 4'h3, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0,   4'h3, 1'b0));
    tbl.push_back(v(1'b0, 4'h3, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd0,   4'h3, 1'b0));
    tbl.push_back(v(1'b0, 4'h3, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd1, 9'd64,  4'h3, 1'b0));
    tbl.push_back(v(1'b0, 4'h3, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd1,   4'h3, 1'b0));
    tbl.push_back(v(1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd1, 9'd65,  4'h2, 1'b0));
    tbl.push_back(v(1'b0, 4'h3, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd2,   4'h3, 1'b0));
    tbl.push_back(v(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd2,   4'h0, 1'b1));
    tbl.push_back(v(1'b0, 4'h3, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd1, 9'd66,  4'h3, 1'b0));

    foreach (tbl[i]) apply(tbl[i]);

    // Redirect thread 0 in the cycle it issues addr 1
    apply(v(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0, 4'hF, 1'b0));
    for (int t = 0; t < 4; t++)
      apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'(t), 9'(t * 64), 4'hF, 1'b0));
    apply(v(1'b0, 4'hF, 1'b0, 1'b1, 2'd0, 9'h1F0, 1'b0, 2'd0, 1'b1, 2'd0, 9'd1, 4'hF, 1'b0));
    for (int t = 1; t < 4; t++)
      apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'(t), 9'(t * 64 + 1), 4'hF, 1'b0));
    apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'h1F0, 4'hF, 1'b0));
    for (int t = 1; t < 4; t++)
      apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'(t), 9'(t * 64 + 2), 4'hF, 1'b0));
    apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd0, 9'h1F1, 4'hF, 1'b0));

    // Halt all threads one by one, each still completing its same-cycle issue
    apply(v(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0, 4'hF, 1'b0));
    apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b1, 2'd0, 1'b1, 2'd0, 9'd0,   4'hE, 1'b0));
    apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b1, 2'd1, 1'b1, 2'd1, 9'd64,  4'hC, 1'b0));
    apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b1, 2'd2, 1'b1, 2'd2, 9'd128, 4'h8, 1'b0));
    apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b1, 2'd3, 1'b1, 2'd3, 9'd192, 4'h0, 1'b1));
    apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd3, 9'd192, 4'h0, 1'b1));
    apply(v(1'b0, 4'hF, 1'b0, 1'b1, 2'd2, 9'h050, 1'b0, 2'd0, 1'b0, 2'd3, 9'd192, 4'h4, 1'b0));
    apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd2, 9'h050, 4'h4, 1'b0));
    // Same-cycle halt and redirect on thread 2: halt wins
    apply(v(1'b0, 4'hF, 1'b0, 1'b1, 2'd2, 9'h077, 1'b1, 2'd2, 1'b1, 2'd2, 9'h051, 4'h0, 1'b1));
    apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd2, 9'h051, 4'h0, 1'b1));

    // PC wrap on thread 3, then mid-stream reset restores boot PCs
    apply(v(1'b1, 4'h8, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0, 4'h8, 1'b0));
    apply(v(1'b0, 4'h8, 1'b0, 1'b1, 2'd3, 9'd511, 1'b0, 2'd0, 1'b1, 2'd3, 9'd192, 4'h8, 1'b0));
    apply(v(1'b0, 4'h8, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd3, 9'd511, 4'h8, 1'b0));
    apply(v(1'b0, 4'h8, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'd3, 9'd0,   4'h8, 1'b0));
    apply(v(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b0, 2'd0, 9'd0,   4'hF, 1'b0));
    for (int t = 0; t < 4; t++)
      apply(v(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 1'b1, 2'(t), 9'(t * 64), 4'hF, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mt_fetch_sched.md
Name: mt_fetch_sched

Overview:
- Parametrised N-thread fetch scheduler and per-thread PC file; successor to the fixed quad-thread front end, generalised in thread count.
- Sits between the multithreaded pipeline's branch/halt resolution logic and instruction memory.
- Picks one eligible thread per cycle, round-robin, and drives its PC to instruction memory.
- Tags the fetch with a thread ID for downstream stages. Supports per-thread enable, halt, redirect and global fetch stall.

Parameters:
- NUM_THREADS, 4, number of hardware threads (2..16).
- TID_WIDTH, 2, thread-ID width; must satisfy 2^TID_WIDTH >= NUM_THREADS.
- PC_WIDTH, 9, instruction address width.
- PC_STEP, 1, increment added to a PC after each issue.
- BOOT_SHIFT, 6, reset PC of thread t is (t << BOOT_SHIFT), truncated to PC_WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- thread_en_i  in  NUM_THREADS  per-thread run enable; bit t = thread t.
- fetch_stall_i  in  1  back-pressure from fetch/decode; freezes issue.
- redirect_valid_i  in  1  PC redirect request (branch taken / exception).
- redirect_tid_i  in  TID_WIDTH  target thread of the redirect.
- redirect_pc_i  in  PC_WIDTH  new PC for the target thread.
- halt_valid_i  in  1  halt request.
- halt_tid_i  in  TID_WIDTH  thread to halt.
- i_mem_addr_o  out  PC_WIDTH  instruction memory address (registered).
- fetch_valid_o  out  1  i_mem_addr_o carries a real fetch this cycle (registered).
- fetch_tid_o  out  TID_WIDTH  owner thread of the fetch (registered).
- active_mask_o  out  NUM_THREADS  thread_en_i & ~halted; combinational from state.
- all_halted_o  out  1  1 when no thread is eligible, i.e. active_mask_o == 0.

Behaviour:
- State:
  - pc[NUM_THREADS] registers.
  - halted[NUM_THREADS] bits.
  - rr_ptr (TID_WIDTH).
  - Output registers for i_mem_addr_o, fetch_valid_o, fetch_tid_o.
- Reset (rst=1 at an edge):
  - pc[t] = t<<BOOT_SHIFT; halted = 0; rr_ptr = NUM_THREADS-1.
  - i_mem_addr_o = 0; fetch_valid_o = 0; fetch_tid_o = 0.
  - Reset overrides every other input, including mid-stream.
- Eligibility:
  - Thread t is eligible iff thread_en_i[t] & ~halted[t].
  - Both are sampled in the same cycle as the selection.
- Selection:
  - Scan tids rr_ptr+1, rr_ptr+2, ..., rr_ptr+NUM_THREADS, each modulo NUM_THREADS.
  - The first eligible thread is sel.
  - Single-cycle combinational search; no dead cycles between threads.
- Issue edge (!fetch_stall_i and at least one thread eligible):
  - i_mem_addr_o <= pc[sel]; fetch_tid_o <= sel; fetch_valid_o <= 1.
  - pc[sel] <= pc[sel]+PC_STEP, wrapping modulo 2^PC_WIDTH.
  - rr_ptr <= sel.
  - Issue latency is one cycle from selection to output.
- Stall edge (fetch_stall_i=1):
  - All three outputs hold their values; no PC increments; rr_ptr holds.
  - Redirect and halt requests are still applied.
- Idle edge (no eligible thread, no stall):
  - fetch_valid_o <= 0; i_mem_addr_o and fetch_tid_o hold; rr_ptr holds.
- Redirect (redirect_valid_i=1, tid < NUM_THREADS):
  - pc[tid] <= redirect_pc_i; halted[tid] <= 0.
  - Overrides the increment when tid == sel in the same cycle. The issue itself still outputs the old pc[sel].
- Halt (halt_valid_i=1, tid < NUM_THREADS):
  - halted[tid] <= 1; the thread is ineligible from the next cycle.
  - A same-cycle issue of that thread still completes.
- Halt and redirect to the same tid in the same cycle: halted=1 and pc=redirect_pc_i.
- tid >= NUM_THREADS on either request: the request is ignored.
- A thread whose thread_en_i drops keeps its PC and resumes from it when re-enabled.

Test Plan:
- Reset release with thread_en_i=4'b1111, no stall -> fetch_valid_o rises on the first post-reset edge. Sequence is (tid, addr) = (0,0),(1,64),(2,128),(3,192),(0,1),(1,65).
- thread_en_i=4'b0101 -> tids alternate 0,2,0,2 with addrs 0,128,1,129. all_halted_o=0 throughout.
- Assert fetch_stall_i for 3 cycles after the fetch of (1,64) -> outputs hold (1,64,valid) for 3 cycles. The next fetch is (2,128); no PC is skipped or duplicated.
- Redirect tid=0 to pc 0x1F0 in the cycle thread 0 issues addr 1 -> output shows addr 1. Thread 0's next fetch is 0x1F0, then 0x1F1.
- Halt tids 0-3 one by one -> fetch_valid_o=0 and all_halted_o=1 once all are halted. Then redirect tid=2 to 0x050 -> next fetch is (2,0x050) and all_halted_o=0.
- Redirect tid=3 to 511, then let it issue twice -> addrs 511 then 0 (wrap). Pulse rst mid-stream -> outputs return to 0, the next fetch is (0,0), and all PCs are back to their boot values.
